ble_usb_frame_buffer: RTL and testbench

Frame-atomic byte buffer between the BLE packet analyzer and the USB transmit logic. It takes the analyzer's byte stream (data, valid, frame envelope) and stores each frame in a circular buffer. A frame is released to the USB side only once it is complete. Frames that do not fit are discarded whole, so the USB side never sees a truncated frame.

---
 rtl/ble_usb_frame_buffer.sv | 177 +++++++++++++++++
 tb/tb_ble_usb_frame_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_usb_frame_buffer.sv
// Frame-atomic byte buffer between the BLE packet analyzer and the USB TX side.
// Frames are written into a circular RAM and only become readable once complete;
// frames that do not fit are discarded whole by rewinding the write pointer.
module ble_usb_frame_buffer #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  input  logic             frame_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_SKIP
  } state_e;

  state_e           state_q, state_d;
  logic             frame_q;
  logic             first_q;
  logic [7:0]       pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             drop_flag_q, drop_flag_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    commit_q, commit_d;
  logic [PW-1:0]    commit_vis_q;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [8:0]       dout_q, dout_d;
  logic             valid_q, valid_d;

  logic [8:0]       ram_q [DEPTH];
  logic             mem_we;
  logic [8:0]       mem_wdata;

  logic [PW-1:0]    used;
  logic             full;
  logic             rd_go;

  assign used = wr_ptr_q - rd_ptr_q;
  assign full = (used == PW'(DEPTH));

  // Input FSM: stage one byte so the final byte can be tagged last at frame end
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    drop_flag_d  = drop_flag_q;
    wr_ptr_d     = wr_ptr_q;
    commit_d     = commit_q;
    drop_cnt_d   = drop_cnt_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        // A frame already high in the first post-reset cycle is skipped whole
        if (first_q && frame_i) begin
          state_d = S_SKIP;
        end else if (!frame_q && frame_i) begin
          state_d      = S_RECV;
          drop_flag_d  = 1'b0;
          pend_valid_d = 1'b0;
        end
      end
      S_RECV: begin
        if (!frame_i) begin
          state_d      = S_IDLE;
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            if (!full && !drop_flag_q) begin
              mem_we    = 1'b1;
              mem_wdata = {1'b1, pend_q};
              wr_ptr_d  = wr_ptr_q + PW'(1);
              commit_d  = wr_ptr_q + PW'(1);
            end else begin
              wr_ptr_d = commit_q;
              if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
              end
            end
          end
        end else if (valid_i) begin
          if (pend_valid_q) begin
            if (full || drop_flag_q) begin
              drop_flag_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_wdata = {1'b0, pend_q};
              wr_ptr_d  = wr_ptr_q + PW'(1);
            end
          end
          pend_d       = data_i;
          pend_valid_d = 1'b1;
        end
      end
      S_SKIP: begin
        if (!frame_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output stage: refill from RAM when empty or being consumed
  always_comb begin
    rd_go    = (rd_ptr_q != commit_vis_q) && (!valid_q || ready_i);
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    if (rd_go) begin
      dout_d   = ram_q[rd_ptr_q[AW-1:0]];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Frame storage; no reset needed, visibility is governed by the pointers
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      ram_q[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end

  // State and pointer registers; the reader sees commit one cycle late,
  // which yields the two-cycle end-of-frame-to-valid latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      frame_q      <= 1'b0;
      first_q      <= 1'b1;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      drop_flag_q  <= 1'b0;
      wr_ptr_q     <= '0;
      commit_q     <= '0;
      commit_vis_q <= '0;
      rd_ptr_q     <= '0;
      drop_cnt_q   <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_i;
      first_q      <= 1'b0;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      drop_flag_q  <= drop_flag_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_q     <= commit_d;
      commit_vis_q <= commit_q;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
    end
  end

  assign data_o     = dout_q[7:0];
  assign last_o     = dout_q[8];
  assign valid_o    = valid_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_ble_usb_frame_buffer.sv
// Directed bench for ble_usb_frame_buffer with a 16-byte buffer.
module tb_ble_usb_frame_buffer;

  logic        clk;
  logic        rst_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        frame_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
  logic [15:0] drop_cnt_o;

  int          n_checks;
  int          n_fail;
  logic [7:0]  fb [0:31];
  logic [8:0]  mon_q [$];
  logic [8:0]  exp_q [$];

  ble_usb_frame_buffer #(.DEPTH(16), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .frame_i    (frame_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted output byte as {last, data}
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) mon_q.push_back({last_o, data_o});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Frame high one cycle, n bytes, then one end cycle; returns just after edge E
  task automatic send_frame(input int n);
    frame_i = 1'b1;
    valid_i = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      data_i  = fb[i];
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    frame_i = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    ready_i = 1'b0;
    frame_i = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    wait_cycles(3);
    rst_i = 1'b0;
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++;
    if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last_o); end
    n_checks++;
    if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_o); end
    n_checks++;
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    ready_i = 1'b1;
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
    send_frame(3);
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_lat_e1: valid_o got %b want 0", valid_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== exp_d[i] || last_o !== (i == 2)) begin
        n_fail++;
        $display("FAIL single_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, valid_o, data_o, last_o, exp_d[i], (i == 2));
      end
    end
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_after: valid_o got %b want 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    mon_q.delete();
    exp_q.delete();
    ready_i = 1'b1;
    fb[0] = 8'h61; fb[1] = 8'h62;
    send_frame(2);
    fb[0] = 8'h71; fb[1] = 8'h72; fb[2] = 8'h73;
    send_frame(3);
    wait_cycles(8);
    exp_q = '{9'h061, 9'h162, 9'h071, 9'h072, 9'h173};
    n_checks++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", mon_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mon_q.delete();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) fb[i] = 8'h51 + 8'(i);
    send_frame(5);
    wait_cycles(2);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== 8'h51 || last_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b d=%h l=%b want v=1 d=51 l=0", i, valid_o, data_o, last_o);
      end
      tick();
    end
    ready_i = 1'b1;
    wait_cycles(8);
    n_checks++;
    if (mon_q.size() != 5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", mon_q.size()); end
    for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== {(i == 4), 8'h51 + 8'(i)}) begin
        n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, mon_q[i], {(i == 4), 8'h51 + 8'(i)});
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    mon_q.delete();
    ready_i = 1'b0;
    for (int i = 0; i < 10; i++) fb[i] = 8'hA0 + 8'(i);
    send_frame(10);
    for (int i = 0; i < 8; i++) fb[i] = 8'hB0 + 8'(i);
    send_frame(8);
    wait_cycles(2);
    n_checks++;
    if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL ovf_drop_b: got %0d want 1", drop_cnt_o); end
    for (int i = 0; i < 6; i++) fb[i] = 8'hC0 + 8'(i);
    send_frame(6);
    wait_cycles(2);
    n_checks++;
    if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL ovf_drop_c: got %0d want 1", drop_cnt_o); end
    ready_i = 1'b1;
    wait_cycles(25);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), 8'hA0 + 8'(i)});
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5), 8'hC0 + 8'(i)});
    n_checks++;
    if (mon_q.size() != 16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", mon_q.size()); end
    for (int i = 0; i < 16 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, mon_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    mon_q.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) fb[i] = 8'(i * 3 + 1);
    send_frame(16);
    wait_cycles(22);
    n_checks++;
    if (mon_q.size() != 16) begin n_fail++; $display("FAIL bnd16_count: got %0d want 16", mon_q.size()); end
    for (int i = 0; i < 16 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== {(i == 15), 8'(i * 3 + 1)}) begin
        n_fail++; $display("FAIL bnd16_byte%0d: got %h want %h", i, mon_q[i], {(i == 15), 8'(i * 3 + 1)});
      end
    end
    n_checks++;
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL bnd16_drop: got %0d want 0", drop_cnt_o); end
    mon_q.delete();
    for (int i = 0; i < 17; i++) fb[i] = 8'hE0 + 8'(i);
    send_frame(17);
    wait_cycles(10);
    n_checks++;
    if (drop_cnt_o !== 16'd1) begin n_fail++; $display("FAIL bnd17_drop: got %0d want 1", drop_cnt_o); end
    n_checks++;
    if (mon_q.size() != 0) begin n_fail++; $display("FAIL bnd17_count: got %0d want 0", mon_q.size()); end
  endtask

  task automatic test_reset_in_frame();
    do_reset();
    mon_q.delete();
    ready_i = 1'b1;
    frame_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin data_i = 8'h90 + 8'(i); valid_i = 1'b1; tick(); end
    valid_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin data_i = 8'h94 + 8'(i); valid_i = 1'b1; tick(); end
    valid_i = 1'b0;
    frame_i = 1'b0;
    tick();
    wait_cycles(8);
    n_checks++;
    if (mon_q.size() != 0) begin n_fail++; $display("FAIL skip_count: got %0d want 0", mon_q.size()); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL skip_valid: got %b want 0", valid_o); end
    n_checks++;
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL skip_drop: got %0d want 0", drop_cnt_o); end
    fb[0] = 8'hA5;
    send_frame(1);
    wait_cycles(6);
    n_checks++;
    if (mon_q.size() != 1 || mon_q[0] !== 9'h1A5) begin
      n_fail++; $display("FAIL after_skip: got n=%0d first=%h want n=1 first=1a5",
                         mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 9'h000);
    end
    mon_q.delete();
    frame_i = 1'b1;
    wait_cycles(3);
    frame_i = 1'b0;
    tick();
    wait_cycles(6);
    n_checks++;
    if (mon_q.size() != 0 || drop_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL empty_frame: got n=%0d drop=%0d want n=0 drop=0", mon_q.size(), drop_cnt_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic ok;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) fb[i] = 8'h30 + 8'(i);
    send_frame(6);
    wait_cycles(3);
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_rst_valid: got %b want 0", valid_o); end
    rst_i = 1'b0;
    tick();
    mon_q.delete();
    fb[0] = 8'h5A; fb[1] = 8'h3C;
    send_frame(2);
    wait_cycles(6);
    n_checks++;
    if (mon_q.size() != 2 || mon_q[0] !== 9'h05A || mon_q[1] !== 9'h13C) begin
      n_fail++; $display("FAIL drain_fresh: got n=%0d want n=2 bytes 05a,13c", mon_q.size());
    end
    for (int f = 0; f < 40; f++) begin
      mon_q.delete();
      for (int i = 0; i < 7; i++) fb[i] = 8'(f * 7 + i);
      send_frame(7);
      wait_cycles(10);
      ok = (mon_q.size() == 7);
      for (int i = 0; i < 7 && i < mon_q.size(); i++)
        if (mon_q[i] !== {(i == 6), 8'(f * 7 + i)}) ok = 1'b0;
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL wrap_frame%0d: got n=%0d first=%h want n=7 first=%h",
                           f, mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : 9'h000, {1'b0, 8'(f * 7)});
      end
    end
    n_checks++;
    if (drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL wrap_drop: got %0d want 0", drop_cnt_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_boundary();
    test_reset_in_frame();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
